// File: rtl/bp_softcore_mem_arbiter.sv
// Two-requester (mem/io) front end for one downstream memory port: round-robin command
// grant with zero-cycle forwarding, in-order response steering via a source-tag FIFO.
module bp_softcore_mem_arbiter #(
  parameter int msg_width_p    = 128,
  parameter int tag_fifo_els_p = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [msg_width_p-1:0]              mem_cmd_i,
  input  logic                                mem_cmd_v_i,
  output logic                                mem_cmd_ready_o,
  input  logic [msg_width_p-1:0]              io_cmd_i,
  input  logic                                io_cmd_v_i,
  output logic                                io_cmd_ready_o,
  output logic [msg_width_p-1:0]              mem_resp_o,
  output logic                                mem_resp_v_o,
  input  logic                                mem_resp_yumi_i,
  output logic [msg_width_p-1:0]              io_resp_o,
  output logic                                io_resp_v_o,
  input  logic                                io_resp_yumi_i,
  output logic [msg_width_p-1:0]              cmd_o,
  output logic                                cmd_v_o,
  input  logic                                cmd_ready_i,
  input  logic [msg_width_p-1:0]              resp_i,
  input  logic                                resp_v_i,
  output logic                                resp_yumi_o,
  output logic [$clog2(tag_fifo_els_p):0]     outstanding_o
);

  localparam int ptr_w = $clog2(tag_fifo_els_p);
  localparam int cnt_w = ptr_w + 1;

  logic             prio_reg;
  logic             tag_mem [tag_fifo_els_p];
  logic [cnt_w-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [cnt_w-1:0] count;
  logic             fifo_full, fifo_empty;
  logic             winner, prio_valid, any_valid;
  logic             head;
  logic             push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign fifo_full  = (count == cnt_w'(tag_fifo_els_p));
  assign fifo_empty = (count == '0);
  assign head       = tag_mem[rd_ptr_reg[ptr_w-1:0]];

  always_comb begin
    prio_valid = prio_reg ? io_cmd_v_i : mem_cmd_v_i;
    winner     = prio_valid ? prio_reg : ~prio_reg;
  end

  assign any_valid = mem_cmd_v_i | io_cmd_v_i;

  assign cmd_o           = winner ? io_cmd_i : mem_cmd_i;
  assign cmd_v_o         = ~reset_i & any_valid & ~fifo_full;
  assign mem_cmd_ready_o = ~reset_i & mem_cmd_v_i & ~winner & cmd_ready_i & ~fifo_full;
  assign io_cmd_ready_o  = ~reset_i & io_cmd_v_i  &  winner & cmd_ready_i & ~fifo_full;
  assign push            = cmd_v_o & cmd_ready_i;

  assign mem_resp_o   = resp_i;
  assign io_resp_o    = resp_i;
  assign mem_resp_v_o = ~reset_i & resp_v_i & ~fifo_empty & ~head;
  assign io_resp_v_o  = ~reset_i & resp_v_i & ~fifo_empty &  head;
  assign resp_yumi_o  = ~reset_i & ~fifo_empty & (head ? io_resp_yumi_i : mem_resp_yumi_i);
  assign pop          = resp_yumi_o;

  assign outstanding_o = reset_i ? '0 : count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        prio_reg   <= ~winner;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Tag storage needs no reset: entries are only read while the pointers say valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem[wr_ptr_reg[ptr_w-1:0]] <= winner;
    end
  end

  // A response with nothing outstanding means the downstream is out of sync.
  assert property (@(posedge clk_i) disable iff (reset_i) !(resp_v_i && fifo_empty))
    else $warning("resp_v_i asserted with no outstanding command");

endmodule

// File: tb/tb_bp_softcore_mem_arbiter.sv
// Randomized bench: per-cycle reference model of the arbitration/steering rules plus a
// response scoreboard fed by accepted commands and drained by a negedge monitor.
module tb_bp_softcore_mem_arbiter;

  localparam int W = 128;
  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [W-1:0] mem_cmd_i, io_cmd_i, mem_resp_o, io_resp_o, cmd_o, resp_i;
  logic         mem_cmd_v_i, mem_cmd_ready_o, io_cmd_v_i, io_cmd_ready_o;
  logic         mem_resp_v_o, mem_resp_yumi_i, io_resp_v_o, io_resp_yumi_i;
  logic         cmd_v_o, cmd_ready_i, resp_v_i, resp_yumi_o;
  logic [$clog2(N):0] outstanding_o;

  always #5 clk_i = ~clk_i;

  bp_softcore_mem_arbiter #(.msg_width_p(W), .tag_fifo_els_p(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_ready_o(mem_cmd_ready_o),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_yumi_i(mem_resp_yumi_i),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .cmd_o(cmd_o), .cmd_v_o(cmd_v_o), .cmd_ready_i(cmd_ready_i),
    .resp_i(resp_i), .resp_v_i(resp_v_i), .resp_yumi_o(resp_yumi_o),
    .outstanding_o(outstanding_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: who owns priority, which source each outstanding command came from,
  // the commands the downstream still owes a response for, and expected responses.
  int           model_prio = 0;
  int           model_tags[$];
  logic [W-1:0] pending[$];
  logic [W-1:0] mem_exp[$];
  logic [W-1:0] io_exp[$];
  bit           mem_acc = 0, io_acc = 0;

  int unsigned p_mem = 0, p_io = 0, p_rdy = 0, p_resp = 0, p_yumi = 0;

  function automatic logic [W-1:0] resp_of(input logic [W-1:0] c);
    return {c[63:0], c[127:64]} ^ {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [W-1:0] rand_msg();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_msg(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every output against the model, then advances the model.
  always @(negedge clk_i) begin : monitor
    int w, head;
    bit full;
    if (reset_i) begin
      chk("reset_cmd_v", int'(cmd_v_o), 0);
      chk("reset_mem_ready", int'(mem_cmd_ready_o), 0);
      chk("reset_io_ready", int'(io_cmd_ready_o), 0);
      chk("reset_mem_resp_v", int'(mem_resp_v_o), 0);
      chk("reset_io_resp_v", int'(io_resp_v_o), 0);
      chk("reset_resp_yumi", int'(resp_yumi_o), 0);
      chk("reset_outstanding", int'(outstanding_o), 0);
      model_prio = 0;
      model_tags.delete();
      pending.delete();
      mem_exp.delete();
      io_exp.delete();
      mem_acc = 0;
      io_acc  = 0;
    end else begin
      full = (model_tags.size() == N);
      head = (model_tags.size() == 0) ? -1 : model_tags[0];
      if (model_prio == 0) w = mem_cmd_v_i ? 0 : (io_cmd_v_i ? 1 : -1);
      else                 w = io_cmd_v_i ? 1 : (mem_cmd_v_i ? 0 : -1);

      chk("cmd_v", int'(cmd_v_o), int'(w >= 0 && !full));
      chk("mem_cmd_ready", int'(mem_cmd_ready_o), int'(w == 0 && cmd_ready_i && !full));
      chk("io_cmd_ready", int'(io_cmd_ready_o), int'(w == 1 && cmd_ready_i && !full));
      chk("mem_resp_v", int'(mem_resp_v_o), int'(resp_v_i && head == 0));
      chk("io_resp_v", int'(io_resp_v_o), int'(resp_v_i && head == 1));
      chk("resp_yumi", int'(resp_yumi_o),
          int'((head == 0 && mem_resp_yumi_i) || (head == 1 && io_resp_yumi_i)));
      chk("outstanding", int'(outstanding_o), model_tags.size());

      mem_acc = mem_cmd_v_i && mem_cmd_ready_o;
      io_acc  = io_cmd_v_i && io_cmd_ready_o;
      if (mem_acc) mem_exp.push_back(resp_of(mem_cmd_i));
      if (io_acc)  io_exp.push_back(resp_of(io_cmd_i));

      if (mem_resp_v_o && mem_resp_yumi_i) begin
        if (mem_exp.size() == 0) chk("mem_resp_unexpected", 1, 0);
        else chk_msg("mem_resp_data", mem_resp_o, mem_exp.pop_front());
      end
      if (io_resp_v_o && io_resp_yumi_i) begin
        if (io_exp.size() == 0) chk("io_resp_unexpected", 1, 0);
        else chk_msg("io_resp_data", io_resp_o, io_exp.pop_front());
      end

      if ((head == 0 && mem_resp_yumi_i) || (head == 1 && io_resp_yumi_i)) begin
        void'(model_tags.pop_front());
        void'(pending.pop_front());
      end
      if (w >= 0 && cmd_ready_i && !full) begin
        chk_msg("cmd_data", cmd_o, (w == 0) ? mem_cmd_i : io_cmd_i);
        pending.push_back((w == 0) ? mem_cmd_i : io_cmd_i);
        model_tags.push_back(w);
        model_prio = (w == 0) ? 1 : 0;
      end
    end
  end

  // Driver: one step per clock, inputs change 1 time unit after the rising edge.
  task automatic cyc();
    int head;
    @(posedge clk_i);
    #1;
    if (!(mem_cmd_v_i && !mem_acc)) begin
      mem_cmd_v_i = ($urandom % 100) < p_mem;
      if (mem_cmd_v_i) mem_cmd_i = rand_msg();
    end
    if (!(io_cmd_v_i && !io_acc)) begin
      io_cmd_v_i = ($urandom % 100) < p_io;
      if (io_cmd_v_i) io_cmd_i = rand_msg();
    end
    cmd_ready_i = ($urandom % 100) < p_rdy;
    resp_v_i    = (pending.size() > 0) && (($urandom % 100) < p_resp);
    resp_i      = (pending.size() > 0) ? resp_of(pending[0]) : rand_msg();
    head        = (model_tags.size() > 0) ? model_tags[0] : -1;
    // Head requester yumis only a presented response; the other side's yumi is noise.
    mem_resp_yumi_i = (head == 0) ? (resp_v_i && ($urandom % 100) < p_yumi) : 1'($urandom);
    io_resp_yumi_i  = (head == 1) ? (resp_v_i && ($urandom % 100) < p_yumi) : 1'($urandom);
  endtask

  task automatic set_p(input int unsigned m, input int unsigned i, input int unsigned r,
                       input int unsigned rs, input int unsigned y);
    p_mem = m; p_io = i; p_rdy = r; p_resp = rs; p_yumi = y;
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    mem_cmd_v_i = 1'b1; io_cmd_v_i = 1'b1; cmd_ready_i = 1'b1;
    resp_v_i = 1'b1; mem_resp_yumi_i = 1'b1; io_resp_yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    mem_cmd_v_i = 1'b0; io_cmd_v_i = 1'b0; cmd_ready_i = 1'b0;
    resp_v_i = 1'b0; mem_resp_yumi_i = 1'b0; io_resp_yumi_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    mem_cmd_i = '0; io_cmd_i = '0; resp_i = '0;
    mem_cmd_v_i = 1'b0; io_cmd_v_i = 1'b0; cmd_ready_i = 1'b0;
    resp_v_i = 1'b0; mem_resp_yumi_i = 1'b0; io_resp_yumi_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    set_p(100, 100, 100, 0, 0);   repeat (6) cyc();    // fill: mem,io,mem,io then blocked
    set_p(100, 100, 100, 100, 100); repeat (4) cyc();  // full with pop and pending command
    set_p(0, 0, 100, 100, 100);   repeat (10) cyc();   // drain
    set_p(0, 100, 100, 0, 0);     repeat (2) cyc();    // io alone while mem holds priority
    set_p(0, 0, 100, 100, 100);   repeat (6) cyc();
    set_p(100, 0, 0, 0, 0);       repeat (4) cyc();    // downstream stall
    set_p(0, 0, 100, 0, 0);       repeat (3) cyc();
    set_p(0, 0, 100, 100, 100);   repeat (6) cyc();
    set_p(100, 100, 100, 0, 0);   repeat (2) cyc();    // two outstanding, then reset
    set_p(0, 0, 0, 0, 0);         repeat (1) cyc();
    do_reset();

    for (int k = 0; k < 40; k++) begin
      set_p($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(0, 100),
            $urandom_range(0, 100), $urandom_range(0, 100));
      repeat (50) cyc();
    end

    set_p(0, 0, 100, 100, 100);
    repeat (30) cyc();
    @(negedge clk_i);
    chk("final_outstanding", int'(outstanding_o), 0);
    chk("final_mem_exp_left", mem_exp.size(), 0);
    chk("final_io_exp_left", io_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
